// File: rtl/mci_pkg.sv
// Shared types and constants for the MCI MCU SRAM access path.
package mci_pkg;

    localparam int unsigned KB = 1024;

    typedef enum logic {
        MCU = 1'b0,
        SOC = 1'b1
    } req_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mci_rr_arb2.sv
// Two-requester round-robin picker; the registered pointer names the requester
// that wins the next tie, and passes to the other side after each completion.
module mci_rr_arb2
    import mci_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    req_e ptr_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr_q == MCU) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q <= MCU;
        end else if (update && (grant != 2'b00)) begin
            ptr_q <= grant[1] ? MCU : SOC;
        end
    end

endmodule

// File: rtl/mci_mcu_sram_arb.sv
// Arbiter and access checker sharing the single-ported MCU SRAM between the MCU
// port and the SoC AXI path, with a dv/hold completion handshake.
module mci_mcu_sram_arb
    import mci_pkg::*;
#(
    parameter int unsigned MCU_SRAM_SIZE_KB = 512,
    parameter int unsigned DATA_W           = 32,
    localparam int unsigned STRB_W          = DATA_W / 8,
    localparam int unsigned SRAM_ADDR_W     = $clog2(MCU_SRAM_SIZE_KB * KB / (DATA_W / 8))
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   mcu_dv,
    input  logic                   mcu_write,
    input  logic [31:0]            mcu_addr,
    input  logic [DATA_W-1:0]      mcu_wdata,
    input  logic [STRB_W-1:0]      mcu_wstrb,
    output logic                   mcu_hold,
    output logic [DATA_W-1:0]      mcu_rdata,
    output logic                   mcu_error,
    input  logic                   soc_dv,
    input  logic                   soc_write,
    input  logic [31:0]            soc_addr,
    input  logic [DATA_W-1:0]      soc_wdata,
    input  logic [STRB_W-1:0]      soc_wstrb,
    input  logic                   soc_priv,
    output logic                   soc_hold,
    output logic [DATA_W-1:0]      soc_rdata,
    output logic                   soc_error,
    input  logic                   exec_region_lock,
    input  logic [31:0]            exec_region_end,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic [STRB_W-1:0]      sram_wstrb,
    input  logic [DATA_W-1:0]      sram_rdata
);

    localparam logic [31:0] SIZE_BYTES = 32'(MCU_SRAM_SIZE_KB * KB);

    state_e              state_q, state_d;
    req_e                owner_q, owner_d;
    logic [1:0]          arb_req, grant, complete;
    logic                arb_update, err_resp;
    req_e                sel;
    logic                sel_write, req_err;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

    // In RD_WAIT the owner is presented alone so the pointer update sees it as the grant.
    assign arb_req = (state_q == RD_WAIT) ? ((owner_q == SOC) ? 2'b10 : 2'b01)
                                          : {soc_dv, mcu_dv};

    mci_rr_arb2 u_rr_arb (
        .clk    (clk),
        .rst_b  (rst_b),
        .req    (arb_req),
        .update (arb_update),
        .grant  (grant)
    );

    assign sel       = grant[1] ? SOC : MCU;
    assign sel_write = (sel == SOC) ? soc_write : mcu_write;
    assign sel_addr  = (sel == SOC) ? soc_addr  : mcu_addr;
    assign sel_wdata = (sel == SOC) ? soc_wdata : mcu_wdata;
    assign sel_wstrb = (sel == SOC) ? soc_wstrb : mcu_wstrb;

    assign req_err = (sel_addr[1:0] != 2'b00) || (sel_addr >= SIZE_BYTES) ||
                     ((sel == SOC) && !soc_priv && exec_region_lock &&
                      (sel_addr < exec_region_end));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            owner_q <= MCU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if ((grant != 2'b00) && !req_err && !sel_write) begin
                    state_d = RD_WAIT;
                    owner_d = sel;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcu_hold   = 1'b0;
        soc_hold   = 1'b0;
        mcu_rdata  = '0;
        soc_rdata  = '0;
        mcu_error  = 1'b0;
        soc_error  = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wstrb = '0;
        complete   = 2'b00;
        err_resp   = 1'b0;
        // Outputs are gated by reset so an in-flight read is dropped immediately.
        if (rst_b) begin
            unique case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        if (req_err) begin
                            complete = grant;
                            err_resp = 1'b1;
                        end else begin
                            sram_cs   = 1'b1;
                            sram_addr = sel_addr[SRAM_ADDR_W+1:2];
                            if (sel_write) begin
                                sram_we    = 1'b1;
                                sram_wdata = sel_wdata;
                                sram_wstrb = sel_wstrb;
                                complete   = grant;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    complete = arb_req;
                    if (owner_q == SOC) soc_rdata = sram_rdata;
                    else                mcu_rdata = sram_rdata;
                end
                default: ;
            endcase
            mcu_hold  = mcu_dv & ~complete[0];
            soc_hold  = soc_dv & ~complete[1];
            mcu_error = err_resp & complete[0];
            soc_error = err_resp & complete[1];
        end
    end

    assign arb_update = |complete;

    a_no_cs_in_wait: assert property (@(posedge clk) disable iff (!rst_b)
        (state_q == RD_WAIT) |-> !sram_cs);

    a_single_completion: assert property (@(posedge clk) disable iff (!rst_b)
        !((mcu_dv && !mcu_hold) && (soc_dv && !soc_hold)));

    a_owner_dv_held: assert property (@(posedge clk) disable iff (!rst_b)
        (state_q == RD_WAIT) |-> ((owner_q == SOC) ? soc_dv : mcu_dv));

endmodule

// File: tb/tb_mci_mcu_sram_arb.sv
// Directed self-checking bench for mci_mcu_sram_arb with a behavioural SRAM.
module tb_mci_mcu_sram_arb;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        mcu_dv, mcu_write, mcu_hold, mcu_error;
    logic [31:0] mcu_addr, mcu_wdata, mcu_rdata;
    logic [3:0]  mcu_wstrb;
    logic        soc_dv, soc_write, soc_priv, soc_hold, soc_error;
    logic [31:0] soc_addr, soc_wdata, soc_rdata;
    logic [3:0]  soc_wstrb;
    logic        exec_region_lock;
    logic [31:0] exec_region_end;
    logic        sram_cs, sram_we;
    logic [16:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int];

    always #5 clk = ~clk;

    mci_mcu_sram_arb #(.MCU_SRAM_SIZE_KB(512), .DATA_W(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .mcu_dv(mcu_dv), .mcu_write(mcu_write), .mcu_addr(mcu_addr),
        .mcu_wdata(mcu_wdata), .mcu_wstrb(mcu_wstrb), .mcu_hold(mcu_hold),
        .mcu_rdata(mcu_rdata), .mcu_error(mcu_error),
        .soc_dv(soc_dv), .soc_write(soc_write), .soc_addr(soc_addr),
        .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb), .soc_priv(soc_priv),
        .soc_hold(soc_hold), .soc_rdata(soc_rdata), .soc_error(soc_error),
        .exec_region_lock(exec_region_lock), .exec_region_end(exec_region_end),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata)
    );

    // Single-port SRAM: writes land at the edge, reads return one cycle later.
    always @(posedge clk) begin : sram_model
        int a;
        logic [31:0] w;
        a = int'(sram_addr);
        w = mem.exists(a) ? mem[a] : 32'h0;
        if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++) if (sram_wstrb[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[a] = w;
        end else if (sram_cs) begin
            sram_rdata <= w;
        end
    end

    task automatic idle_inputs();
        mcu_dv = 0; mcu_write = 0; mcu_addr = '0; mcu_wdata = '0; mcu_wstrb = '0;
        soc_dv = 0; soc_write = 0; soc_addr = '0; soc_wdata = '0; soc_wstrb = '0;
        soc_priv = 0; exec_region_lock = 0; exec_region_end = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_b = 0;
        @(negedge clk);
        rst_b = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_b = 0;
        mcu_dv = 1; soc_dv = 1;
        #1;
        checks++; if (mcu_hold !== 1'b0) begin errors++; $display("FAIL reset_mcu_hold: got %b want 0", mcu_hold); end
        checks++; if (soc_hold !== 1'b0) begin errors++; $display("FAIL reset_soc_hold: got %b want 0", soc_hold); end
        checks++; if ({sram_cs, sram_we} !== 2'b00) begin errors++; $display("FAIL reset_cs_we: got %b want 00", {sram_cs, sram_we}); end
        checks++; if ({sram_addr, sram_wdata, sram_wstrb} !== '0) begin errors++; $display("FAIL reset_sram_bus: got %h want 0", {sram_addr, sram_wdata, sram_wstrb}); end
        checks++; if ({mcu_rdata, soc_rdata, mcu_error, soc_error} !== '0) begin errors++; $display("FAIL reset_resp: got %h want 0", {mcu_rdata, soc_rdata, mcu_error, soc_error}); end
        @(negedge clk);
        mcu_dv = 0; soc_dv = 0;
        rst_b = 1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        mcu_dv = 1; mcu_write = 1; mcu_addr = 32'h100; mcu_wdata = 32'hDEADBEEF; mcu_wstrb = 4'hF;
        #1;
        checks++; if ({mcu_hold, mcu_error} !== 2'b00) begin errors++; $display("FAIL wr_complete: hold/err got %b want 00", {mcu_hold, mcu_error}); end
        checks++; if ({sram_cs, sram_we} !== 2'b11) begin errors++; $display("FAIL wr_cs_we: got %b want 11", {sram_cs, sram_we}); end
        checks++; if ({sram_addr, sram_wdata, sram_wstrb} !== {17'h40, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL wr_bus: got %h want %h", {sram_addr, sram_wdata, sram_wstrb}, {17'h40, 32'hDEADBEEF, 4'hF}); end
        @(negedge clk);
        mcu_write = 0; mcu_wdata = '0; mcu_wstrb = '0;
        #1;
        checks++; if ({mcu_hold, sram_cs, sram_we} !== 3'b110) begin errors++; $display("FAIL rd_grant: hold/cs/we got %b want 110", {mcu_hold, sram_cs, sram_we}); end
        checks++; if (sram_addr !== 17'h40) begin errors++; $display("FAIL rd_addr: got %h want 40", sram_addr); end
        @(negedge clk);
        #1;
        checks++; if ({mcu_hold, mcu_error, sram_cs} !== 3'b000) begin errors++; $display("FAIL rd_done: hold/err/cs got %b want 000", {mcu_hold, mcu_error, sram_cs}); end
        checks++; if (mcu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", mcu_rdata); end
        @(negedge clk);
        mcu_dv = 0;
    endtask

    task automatic test_rr_pair();
        apply_reset();
        mem[4] = 32'h1111_0010; mem[8] = 32'h2222_0020; mem[12] = 32'h3333_0030;
        mcu_dv = 1; mcu_addr = 32'h10; soc_dv = 1; soc_addr = 32'h20;
        #1;
        checks++; if ({mcu_hold, soc_hold, sram_cs} !== 3'b111 || sram_addr !== 17'h4) begin errors++; $display("FAIL rr_first_tie: hold/cs %b addr %h want 111 addr 4", {mcu_hold, soc_hold, sram_cs}, sram_addr); end
        @(negedge clk);
        #1;
        checks++; if ({mcu_hold, soc_hold, sram_cs} !== 3'b010) begin errors++; $display("FAIL rr_mcu_done: hold/cs got %b want 010", {mcu_hold, soc_hold, sram_cs}); end
        checks++; if (mcu_rdata !== 32'h1111_0010 || soc_rdata !== 32'h0) begin errors++; $display("FAIL rr_mcu_data: mcu %h soc %h want 11110010 0", mcu_rdata, soc_rdata); end
        @(negedge clk);
        mcu_addr = 32'h30;
        #1;
        checks++; if ({mcu_hold, soc_hold, sram_cs} !== 3'b111 || sram_addr !== 17'h8) begin errors++; $display("FAIL rr_second_tie: hold/cs %b addr %h want 111 addr 8", {mcu_hold, soc_hold, sram_cs}, sram_addr); end
        @(negedge clk);
        #1;
        checks++; if ({mcu_hold, soc_hold} !== 2'b10 || soc_rdata !== 32'h2222_0020) begin errors++; $display("FAIL rr_soc_done: hold %b data %h want 10 22220020", {mcu_hold, soc_hold}, soc_rdata); end
        @(negedge clk);
        soc_dv = 0;
        #1;
        checks++; if ({mcu_hold, sram_cs} !== 2'b11 || sram_addr !== 17'hC) begin errors++; $display("FAIL rr_mcu_again: hold/cs %b addr %h want 11 addr c", {mcu_hold, sram_cs}, sram_addr); end
        @(negedge clk);
        #1;
        checks++; if (mcu_hold !== 1'b0 || mcu_rdata !== 32'h3333_0030) begin errors++; $display("FAIL rr_mcu_again_done: hold %b data %h want 0 33330030", mcu_hold, mcu_rdata); end
        @(negedge clk);
        mcu_dv = 0;
    endtask

    task automatic test_protection();
        @(negedge clk);
        exec_region_lock = 1; exec_region_end = 32'h8000;
        soc_dv = 1; soc_write = 1; soc_priv = 0; soc_addr = 32'h4000;
        soc_wdata = 32'h1234_5678; soc_wstrb = 4'hF;
        #1;
        checks++; if ({soc_hold, soc_error, sram_cs} !== 3'b010 || soc_rdata !== 32'h0) begin errors++; $display("FAIL prot_wr_block: hold/err/cs %b rdata %h want 010 0", {soc_hold, soc_error, sram_cs}, soc_rdata); end
        @(negedge clk);
        soc_priv = 1;
        #1;
        checks++; if ({soc_hold, soc_error, sram_cs, sram_we} !== 4'b0011 || sram_addr !== 17'h1000) begin errors++; $display("FAIL prot_wr_priv: hold/err/cs/we %b addr %h want 0011 1000", {soc_hold, soc_error, sram_cs, sram_we}, sram_addr); end
        @(negedge clk);
        soc_priv = 0; soc_write = 0;
        #1;
        checks++; if ({soc_hold, soc_error, sram_cs} !== 3'b010) begin errors++; $display("FAIL prot_rd_block: hold/err/cs got %b want 010", {soc_hold, soc_error, sram_cs}); end
        @(negedge clk);
        soc_dv = 0; exec_region_lock = 0; exec_region_end = '0;
    endtask

    task automatic test_range_align();
        @(negedge clk);
        soc_dv = 1; soc_write = 0; soc_priv = 1; soc_addr = 32'h0008_0000;
        #1;
        checks++; if ({soc_hold, soc_error, sram_cs} !== 3'b010 || soc_rdata !== 32'h0) begin errors++; $display("FAIL range_soc: hold/err/cs %b rdata %h want 010 0", {soc_hold, soc_error, sram_cs}, soc_rdata); end
        @(negedge clk);
        soc_dv = 0;
        mcu_dv = 1; mcu_write = 0; mcu_addr = 32'h2;
        #1;
        checks++; if ({mcu_hold, mcu_error, sram_cs} !== 3'b010 || mcu_rdata !== 32'h0) begin errors++; $display("FAIL align_mcu: hold/err/cs %b rdata %h want 010 0", {mcu_hold, mcu_error, sram_cs}, mcu_rdata); end
        @(negedge clk);
        mcu_dv = 0;
    endtask

    task automatic test_back_to_back();
        int mcu_cnt = 0, soc_cnt = 0, mcu_wait = 0, soc_wait = 0, last = -1, cyc = 0;
        bit mcu_done = 0, soc_done = 0;
        for (int k = 0; k < 50; k++) begin
            mem[32'h100 + k] = 32'hB000_0000 + k;
            mem[32'h200 + k] = 32'hC000_0000 + k;
        end
        @(negedge clk);
        soc_priv = 1;
        mcu_dv = 1; mcu_addr = 32'h400; soc_dv = 1; soc_addr = 32'h800;
        while ((mcu_cnt + soc_cnt) < 100 && cyc < 600) begin
            if (cyc != 0) @(negedge clk);
            if (mcu_done) begin
                mcu_wait = 0;
                if (mcu_cnt < 50) mcu_addr = 32'h400 + 32'(4 * mcu_cnt); else mcu_dv = 0;
            end
            if (soc_done) begin
                soc_wait = 0;
                if (soc_cnt < 50) soc_addr = 32'h800 + 32'(4 * soc_cnt); else soc_dv = 0;
            end
            #1;
            cyc++;
            mcu_wait += int'(mcu_dv);
            soc_wait += int'(soc_dv);
            mcu_done = mcu_dv && !mcu_hold;
            soc_done = soc_dv && !soc_hold;
            if (mcu_done) begin
                checks++; if (mcu_rdata !== 32'hB000_0000 + 32'(mcu_cnt) || last == 0 || mcu_wait > 4) begin errors++; $display("FAIL b2b_mcu %0d: data %h wait %0d last %0d want %h wait<=4 last!=0", mcu_cnt, mcu_rdata, mcu_wait, last, 32'hB000_0000 + 32'(mcu_cnt)); end
                last = 0; mcu_cnt++;
            end
            if (soc_done) begin
                checks++; if (soc_rdata !== 32'hC000_0000 + 32'(soc_cnt) || last == 1 || soc_wait > 4) begin errors++; $display("FAIL b2b_soc %0d: data %h wait %0d last %0d want %h wait<=4 last!=1", soc_cnt, soc_rdata, soc_wait, last, 32'hC000_0000 + 32'(soc_cnt)); end
                last = 1; soc_cnt++;
            end
        end
        checks++; if (mcu_cnt + soc_cnt !== 100) begin errors++; $display("FAIL b2b_total: got %0d completions want 100", mcu_cnt + soc_cnt); end
        @(negedge clk);
        mcu_dv = 0; soc_dv = 0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        mcu_dv = 1; mcu_write = 0; mcu_addr = 32'h10;
        soc_dv = 1; soc_write = 0; soc_addr = 32'h20; soc_priv = 1;
        @(posedge clk);
        #2;
        checks++; if ((mcu_hold ^ soc_hold) !== 1'b1 || sram_cs !== 1'b0) begin errors++; $display("FAIL mid_rd_wait: holds %b cs %b want one held, cs 0", {mcu_hold, soc_hold}, sram_cs); end
        rst_b = 0;
        #1;
        checks++; if ({sram_cs, mcu_hold, soc_hold} !== 3'b000) begin errors++; $display("FAIL mid_rd_reset: cs/holds got %b want 000", {sram_cs, mcu_hold, soc_hold}); end
        checks++; if ({mcu_rdata, soc_rdata} !== '0) begin errors++; $display("FAIL mid_rd_rdata: got %h want 0", {mcu_rdata, soc_rdata}); end
        @(negedge clk);
        mcu_dv = 0; soc_dv = 0;
        @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        mcu_dv = 1; mcu_addr = 32'h100;
        #1;
        checks++; if ({mcu_hold, sram_cs, sram_we} !== 3'b110 || sram_addr !== 17'h40) begin errors++; $display("FAIL post_rst_grant: hold/cs/we %b addr %h want 110 40", {mcu_hold, sram_cs, sram_we}, sram_addr); end
        @(negedge clk);
        #1;
        checks++; if ({mcu_hold, mcu_error} !== 2'b00 || mcu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL post_rst_done: hold/err %b data %h want 00 deadbeef", {mcu_hold, mcu_error}, mcu_rdata); end
        @(negedge clk);
        mcu_dv = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rr_pair();
        test_protection();
        test_range_align();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
